uart_tx: RTL and testbench

Byte-serial UART transmitter, 8 data bits, LSB first, optional parity, one stop bit. It consumes the `tx_data`/`tx_start` byte handshake driven by the command handlers (counter reply, capture dump) and drives the FPGA-to-host serial line. It returns `tx_active`/`tx_done` so handlers can pace bytes back-to-back without a FIFO.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8 data bits LSB first, optional
// even/odd parity, one stop bit. Fixed integer baud divider, no FIFO; the
// tx_active/tx_done pair lets a handler pace bytes back-to-back.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_serial
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    latched;
  logic          bit_end;
  logic          parity_bit;

  assign bit_end = (baud_cnt == LAST_CNT);

  // Parity comes from the byte captured at accept time, so later tx_data
  // changes cannot corrupt a frame in flight.
  assign parity_bit = (PARITY == 2) ? ~(^latched) : (^latched);

  // Busy includes the request cycle itself so a handler that raised
  // tx_start sees busy before the FSM has left IDLE.
  assign tx_active = (state != S_IDLE) || tx_start;

  // Frame sequencer; tx_serial is registered and updated together with the
  // state so the line changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      latched   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_serial <= 1'b1;
          if (tx_start) begin
            shift     <= tx_data;
            latched   <= tx_data;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_serial <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            tx_serial <= shift[0];
            state     <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx_serial <= parity_bit;
                state     <= S_PARITY;
              end else begin
                tx_serial <= 1'b1;
                state     <= S_STOP;
              end
            end else begin
              tx_serial <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            tx_serial <= 1'b1;
            state     <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          tx_serial <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            tx_done  <= 1'b1;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt  <= '0;
          tx_serial <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (no / even / odd parity) at 4 clocks per
// bit, checked against a bit-time line model and a midpoint-sampling
// receiver on the no-parity instance.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s  [3];
  logic [7:0] data_s   [3];
  logic       active_s [3];
  logic       done_s   [3];
  logic       serial_s [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(gi)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_start  (start_s[gi]),
        .tx_data   (data_s[gi]),
        .tx_active (active_s[gi]),
        .tx_done   (done_s[gi]),
        .tx_serial (serial_s[gi])
      );
    end
  endgenerate

  // Receiver for instance 0: start-bit detect, sample each bit mid-cell.
  logic [7:0] rx_q[$];
  int         done_cnt0 = 0;
  int         frame_err = 0;
  int         mon_pos   = -1;
  logic [7:0] mon_byte  = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        mon_pos = -1;
      end else begin
        if (done_s[0] === 1'b1) done_cnt0++;
        if (mon_pos < 0) begin
          if (serial_s[0] === 1'b0) mon_pos = 0;
        end else begin
          mon_pos++;
        end
        if (mon_pos >= 6 && mon_pos <= 34 && ((mon_pos - 6) % 4) == 0)
          mon_byte[(mon_pos - 6) / 4] = serial_s[0];
        if (mon_pos == 38) begin
          if (serial_s[0] !== 1'b1) frame_err++;
          rx_q.push_back(mon_byte);
        end
        if (mon_pos == 39) mon_pos = -1;
      end
    end
  end

  // Expected line for one frame, index k = cycle E0+1+k.
  function automatic logic [43:0] model_line(input int p, input logic [7:0] b);
    logic [43:0] v;
    int nbits;
    int bitn;
    v = '0;
    nbits = (p != 0) ? 11 : 10;
    for (int k = 0; k < nbits * CPB; k++) begin
      bitn = k / CPB;
      if (bitn == 0)                v[k] = 1'b0;
      else if (bitn <= 8)           v[k] = b[bitn - 1];
      else if (bitn == 9 && p != 0) v[k] = (p == 1) ? (^b) : ~(^b);
      else                          v[k] = 1'b1;
    end
    return v;
  endfunction

  // Called in the E0 cycle (tx_start already driven high, #1 elapsed).
  task automatic check_frame(input int idx, input logic [7:0] b);
    logic [43:0] exp_line;
    logic [43:0] got_line;
    int L;
    int active_bad;
    int dcnt;
    int dat;
    L = ((idx != 0) ? 11 : 10) * CPB;
    exp_line = model_line(idx, b);
    got_line = '0;
    active_bad = 0;
    dcnt = 0;
    dat = -1;
    if (active_s[idx] !== 1'b1) active_bad++;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      start_s[idx] = 1'b0;
      data_s[idx] = 8'($urandom);
      #1;
      if (k <= L) begin
        got_line[k - 1] = serial_s[idx];
        if (active_s[idx] !== 1'b1) active_bad++;
      end else if (active_s[idx] !== 1'b0) begin
        active_bad++;
      end
      if (done_s[idx] === 1'b1) begin
        dcnt++;
        dat = k;
      end
    end
    checks++;
    if (got_line !== exp_line) begin
      failures++;
      $display("FAIL frame_line dut%0d data=%02h got=%h expected=%h", idx, b, got_line, exp_line);
    end
    checks++;
    if (active_bad != 0) begin
      failures++;
      $display("FAIL frame_active dut%0d data=%02h bad_cycles=%0d expected=0", idx, b, active_bad);
    end
    checks++;
    if (dcnt != 1 || dat != L + 1) begin
      failures++;
      $display("FAIL frame_done dut%0d data=%02h pulses=%0d at=%0d expected=1 at %0d", idx, b, dcnt, dat, L + 1);
    end
    $display("frame dut%0d data=%02h len=%0d", idx, b, L);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] b);
    @(negedge clk);
    start_s[idx] = 1'b1;
    data_s[idx] = b;
    #1;
    check_frame(idx, b);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      data_s[i] = 8'h00;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (serial_s[i] !== 1'b1 || active_s[i] !== 1'b0 || done_s[i] !== 1'b0) begin
          failures++;
          $display("FAIL reset_idle dut%0d cyc%0d serial=%b active=%b done=%b expected 1/0/0",
                   i, c, serial_s[i], active_s[i], done_s[i]);
        end
      end
    end
    @(negedge clk);
    start_s[0] = 1'b1;
    data_s[0] = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (serial_s[0] !== 1'b1 || done_s[0] !== 1'b0) begin
        failures++;
        $display("FAIL reset_start_held cyc%0d serial=%b done=%b expected 1/0", c, serial_s[0], done_s[0]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_frame(0, 8'hC3);
    $display("test_reset done");
  endtask

  task automatic test_single();
    send_frame(0, 8'h55);
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07);
    send_frame(2, 8'h07);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++)
      for (int n = 0; n < 4; n++)
        send_frame(i, 8'($urandom));
  endtask

  task automatic test_pacing();
    int w;
    rx_q.delete();
    done_cnt0 = 0;
    frame_err = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      start_s[0] = 1'b1;
      data_s[0] = 8'(n);
      @(negedge clk);
      start_s[0] = 1'b0;
      #1;
      checks++;
      if (active_s[0] !== 1'b1) begin
        failures++;
        $display("FAIL pacing_busy_after_start n=%0d active=%b expected 1", n, active_s[0]);
      end
      w = 0;
      while (active_s[0] !== 1'b0 && w < 100) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (w >= 100) begin
        checks++;
        failures++;
        $display("FAIL pacing_timeout n=%0d active=%b expected 0 within 100 cycles", n, active_s[0]);
      end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (rx_q.size() != 3 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'h01 || rx_q[2] !== 8'h02) begin
      failures++;
      $display("FAIL pacing_bytes got=%p expected 00 01 02", rx_q);
    end
    checks++;
    if (done_cnt0 != 3 || frame_err != 0) begin
      failures++;
      $display("FAIL pacing_done pulses=%0d ferr=%0d expected 3/0", done_cnt0, frame_err);
    end
    $display("test_pacing frames=%0d", rx_q.size());
  endtask

  task automatic test_busy();
    rx_q.delete();
    done_cnt0 = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    data_s[0] = 8'h3C;
    @(negedge clk);
    start_s[0] = 1'b0;
    data_s[0] = 8'($urandom);
    repeat (15) @(negedge clk);
    start_s[0] = 1'b1;
    data_s[0] = 8'hA5;
    #1;
    checks++;
    if (active_s[0] !== 1'b1) begin
      failures++;
      $display("FAIL busy_active active=%b expected 1", active_s[0]);
    end
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || done_cnt0 != 1) begin
      failures++;
      $display("FAIL busy_ignored got=%p pulses=%0d expected 3c and 1 pulse", rx_q, done_cnt0);
    end
    $display("test_busy frames=%0d", rx_q.size());
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    rx_q.delete();
    done_cnt0 = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    data_s[0] = b0;
    @(negedge clk);
    data_s[0] = b1;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (done_s[0] !== 1'b1 || active_s[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_cycle done=%b active=%b expected 1/1", done_s[0], active_s[0]);
    end
    @(negedge clk);
    start_s[0] = 1'b0;
    data_s[0] = ~b1;
    #1;
    checks++;
    if (serial_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_zero_gap serial=%b expected 0", serial_s[0]);
    end
    repeat (45) @(negedge clk);
    #1;
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== b0 || rx_q[1] !== b1 || done_cnt0 != 2) begin
      failures++;
      $display("FAIL b2b_bytes got=%p pulses=%0d expected %02h %02h and 2 pulses", rx_q, done_cnt0, b0, b1);
    end
    $display("test_back_to_back %02h %02h", b0, b1);
  endtask

  task automatic test_abort();
    int dbad;
    rx_q.delete();
    done_cnt0 = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    data_s[0] = 8'hFF;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (serial_s[0] !== 1'b1 || active_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_state serial=%b active=%b done=%b expected 1/0/0", serial_s[0], active_s[0], done_s[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    dbad = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (done_s[0] !== 1'b0 || serial_s[0] !== 1'b1) dbad++;
    end
    checks++;
    if (dbad != 0 || rx_q.size() != 0 || done_cnt0 != 0) begin
      failures++;
      $display("FAIL abort_quiet bad=%0d frames=%0d pulses=%0d expected 0/0/0", dbad, rx_q.size(), done_cnt0);
    end
    send_frame(0, 8'h81);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
      failures++;
      $display("FAIL abort_recovery got=%p expected 81", rx_q);
    end
    $display("test_abort recovered frames=%0d", rx_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_random();
    test_pacing();
    test_busy();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
